// File: rtl/gfx_dma_writer_if.sv
// CPU write port and VRAM-side outputs of the gfx DMA writer.
interface gfx_dma_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [7:0]        i_wr_data;
  logic              o_wr_ready;
  logic              i_blank;
  logic              o_addr_sel;
  logic [ADDR_W-1:0] o_dma_addr;
  logic [7:0]        o_dma_data;
  logic              o_data_oe;
  logic              o_vram_we_n;
  logic              o_full;
  logic              o_empty;
  logic [LVL_W-1:0]  o_level;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_blank,
    output o_wr_ready, o_addr_sel, o_dma_addr, o_dma_data, o_data_oe,
           o_vram_we_n, o_full, o_empty, o_level
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_blank,
    input  o_wr_ready, o_addr_sel, o_dma_addr, o_dma_data, o_data_oe,
           o_vram_we_n, o_full, o_empty, o_level
  );
endinterface

// File: rtl/gfx_dma_writer.sv
// DMA writer: buffers CPU pixel writes and drains them into VRAM during blanking.
//
// state  | meaning
// IDLE   | bus belongs to VGA; waiting for a queued entry and blank
// SETUP  | DMA owns the bus, address/data settling
// STROBE | write strobe low for one clock
// HOLD   | address/data hold; may chain straight into the next write
//
// Bus outputs are a registered decode of the state, so they trail the state by
// one clock. The popped entry is staged for one clock as well, keeping address
// and data stable through the visible HOLD cycle of a burst.
module gfx_dma_writer #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  gfx_dma_writer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state_q, state_nxt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q, level_nxt;
  logic              full_q, empty_q;
  logic              push, pop, pop_q;
  logic [ENT_W-1:0]  stage_q;
  logic              sel_d, oe_d, we_n_d;
  logic              sel_q, oe_q, we_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  assign push = bus.i_wr_valid && !full_q;

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {bus.i_wr_addr, bus.i_wr_data};
  end

  // Next fill level; simultaneous push and pop leaves it unchanged
  always_comb begin
    level_nxt = level_q;
    if (push && !pop)      level_nxt = level_q + LVL_W'(1);
    else if (pop && !push) level_nxt = level_q - LVL_W'(1);
  end

  // Pointers, level and registered flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_W'(DEPTH));
      empty_q <= (level_nxt == '0);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // FSM next state and pop decision; blank only matters in IDLE and HOLD
  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && bus.i_blank) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (!empty_q && bus.i_blank) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    sel_d  = (state_q != IDLE);
    oe_d   = (state_q != IDLE);
    we_n_d = (state_q != STROBE);
  end

  // Registered bus controls and address/data path
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q   <= 1'b0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      pop_q   <= 1'b0;
      stage_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      oe_q   <= oe_d;
      we_n_q <= we_n_d;
      pop_q  <= pop;
      if (pop)   stage_q <= mem[rd_ptr];
      if (pop_q) {addr_q, data_q} <= stage_q;
    end
  end

  assign bus.o_wr_ready  = !full_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_level     = level_q;
  assign bus.o_addr_sel  = sel_q;
  assign bus.o_data_oe   = oe_q;
  assign bus.o_vram_we_n = we_n_q;
  assign bus.o_dma_addr  = addr_q;
  assign bus.o_dma_data  = data_q;
endmodule

// File: tb/tb_gfx_dma_writer.sv
// Scoreboard bench for gfx_dma_writer: stimulus queues expected VRAM writes,
// a negedge monitor checks every strobe against the queue.
module tb_gfx_dma_writer;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;

  gfx_dma_writer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  gfx_dma_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] sb [$];
  int          strobe_count = 0;
  int          strobe_cyc [$];
  int          sel_falls = 0;
  int          cyc = 0;
  logic        prev_we_n = 1'b1;
  logic        prev_sel  = 1'b0;
  logic [23:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_vram_we_n === 1'b0) begin
        strobe_count++;
        strobe_cyc.push_back(cyc);
        check("strobe_one_cycle", {31'd0, prev_we_n}, 1);
        check("strobe_sel", {31'd0, bus.o_addr_sel}, 1);
        check("strobe_oe", {31'd0, bus.o_data_oe}, 1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                   bus.o_dma_addr, bus.o_dma_data);
        end else begin
          mon_exp = sb.pop_front();
          check("wr_addr", {16'd0, bus.o_dma_addr}, {16'd0, mon_exp[23:8]});
          check("wr_data", {24'd0, bus.o_dma_data}, {24'd0, mon_exp[7:0]});
        end
      end
      if (prev_sel && !bus.o_addr_sel) sel_falls++;
      prev_we_n = bus.o_vram_we_n;
      prev_sel  = bus.o_addr_sel;
    end else begin
      prev_we_n = 1'b1;
      prev_sel  = 1'b0;
    end
  end

  task automatic push_entry(input logic [15:0] a, input logic [7:0] d, input bit exp);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
    if (exp) sb.push_back({a, d});
    @(posedge clk);
    #1;
    bus.i_wr_valid = 1'b0;
  endtask

  // Wait until FIFO empty and bus back with VGA for several consecutive cycles
  task automatic drain(input string nm);
    int quiet = 0;
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_empty && !bus.o_addr_sel && bus.o_vram_we_n) quiet++;
      else quiet = 0;
      if (quiet >= 5) break;
    end
    check({nm, "_drain_done"}, {31'd0, (i < 200)}, 1);
    check({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_sel  [6];
    logic exp_we_n [6];
    int   s0;
    int   i;

    rst = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_blank    = 1'b0;
    #2 rst = 1'b1;
    #10;
    check("rst_sel", {31'd0, bus.o_addr_sel}, 0);
    check("rst_oe", {31'd0, bus.o_data_oe}, 0);
    check("rst_we_n", {31'd0, bus.o_vram_we_n}, 1);
    check("rst_addr", {16'd0, bus.o_dma_addr}, 0);
    check("rst_data", {24'd0, bus.o_dma_data}, 0);
    check("rst_empty", {31'd0, bus.o_empty}, 1);
    check("rst_full", {31'd0, bus.o_full}, 0);
    check("rst_level", {28'd0, bus.o_level}, 0);
    check("rst_ready", {31'd0, bus.o_wr_ready}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single write: cycle-by-cycle timing relative to the push edge
    exp_sel  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_we_n = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.i_blank = 1'b1;
    push_entry(16'h1234, 8'hAB, 1'b1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("single_sel_k%0d", n), {31'd0, bus.o_addr_sel}, {31'd0, exp_sel[n]});
      check($sformatf("single_we_n_k%0d", n), {31'd0, bus.o_vram_we_n}, {31'd0, exp_we_n[n]});
      if (n >= 2 && n <= 4) begin
        check($sformatf("single_addr_k%0d", n), {16'd0, bus.o_dma_addr}, 32'h1234);
        check($sformatf("single_data_k%0d", n), {24'd0, bus.o_dma_data}, 32'hAB);
      end
    end
    drain("single");
    check("single_addr_kept", {16'd0, bus.o_dma_addr}, 32'h1234);

    // Burst of four back-to-back pushes
    strobe_cyc.delete();
    sel_falls = 0;
    push_entry(16'h1000, 8'h01, 1'b1);
    push_entry(16'h1111, 8'h22, 1'b1);
    push_entry(16'hFFFF, 8'hFF, 1'b1);
    push_entry(16'h0000, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("burst_strobes", strobe_cyc.size(), 4);
    if (strobe_cyc.size() == 4)
      for (int j = 1; j < 4; j++)
        check($sformatf("burst_spacing_%0d", j), strobe_cyc[j] - strobe_cyc[j-1], 3);
    check("burst_sel_falls", sel_falls, 1);
    drain("burst");

    // Full: blank low, nine pushes, the ninth is dropped
    bus.i_blank = 1'b0;
    for (i = 0; i < 9; i++)
      push_entry(16'h2000 + 16'(i), 8'(8'h80 + i), (i < 8));
    check("full_flag", {31'd0, bus.o_full}, 1);
    check("full_ready", {31'd0, bus.o_wr_ready}, 0);
    check("full_level", {28'd0, bus.o_level}, 8);
    check("full_empty", {31'd0, bus.o_empty}, 0);
    s0 = strobe_count;
    bus.i_blank = 1'b1;
    drain("full");
    check("full_writes", strobe_count - s0, 8);
    check("full_level_after", {28'd0, bus.o_level}, 0);

    // Blank falls while the bus shows SETUP: that write completes, next waits
    s0 = strobe_count;
    push_entry(16'h3300, 8'h33, 1'b1);
    push_entry(16'h3301, 8'h34, 1'b1);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_addr_sel) break;
    end
    check("blank_setup_seen", {31'd0, (i < 10)}, 1);
    bus.i_blank = 1'b0;
    repeat (10) @(negedge clk);
    check("blank_one_write", strobe_count - s0, 1);
    check("blank_level", {28'd0, bus.o_level}, 1);
    check("blank_sel_idle", {31'd0, bus.o_addr_sel}, 0);
    bus.i_blank = 1'b1;
    drain("blank");
    check("blank_two_writes", strobe_count - s0, 2);

    // Simultaneous push/pop through pointer wrap
    bus.i_blank = 1'b0;
    push_entry(16'h4A00, 8'hE0, 1'b1);
    push_entry(16'h4A01, 8'hE1, 1'b1);
    bus.i_blank = 1'b1;
    for (i = 0; i < 20; i++) begin
      push_entry(16'h4000 + 16'(i * 257), 8'(8'h10 + i), 1'b1);
      repeat (2) begin
        @(negedge clk);
        check($sformatf("wrap_level_%0d", i), {28'd0, bus.o_level}, 2);
        @(posedge clk);
        #1;
      end
    end
    drain("wrap");

    // Reset in the middle of a strobe
    push_entry(16'h0F0F, 8'h5A, 1'b1);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_vram_we_n === 1'b0) break;
    end
    check("midrst_strobe_seen", {31'd0, (i < 10)}, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_we_n", {31'd0, bus.o_vram_we_n}, 1);
    check("midrst_sel", {31'd0, bus.o_addr_sel}, 0);
    check("midrst_oe", {31'd0, bus.o_data_oe}, 0);
    check("midrst_empty", {31'd0, bus.o_empty}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_idle", {31'd0, bus.o_addr_sel}, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
